// File: rtl/mem_lsu_pkg.sv
// Shared types for the MEM-stage load/store unit.
// Access-size codes and the request FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE,
        WAIT
    } lsu_state_e;

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory request/acknowledge bus between the LSU and dmem.
// The LSU is the master; the memory answers with ack/rdata.
interface mem_lsu_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ack, rdata
    );

endinterface

// File: rtl/mem_lsu_load_fmt.sv
// Load data formatter: lane select plus sign/zero extension.
// Purely combinational; fed with the word read from dmem.
module lsu_load_fmt
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [15:0] h;
    logic [7:0]  b;

    assign h = 16'(rdata >> {off, 3'b000});
    assign b = h[7:0];

    always_comb begin
        data = rdata;
        unique case (1'b1)
            (funct3 == F3_B):  data = {{24{b[7]}}, b};
            (funct3 == F3_H):  data = {{16{h[15]}}, h};
            (funct3 == F3_BU): data = {24'd0, b};
            (funct3 == F3_HU): data = {16'd0, h};
            default:           data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: dmem req/ack transaction, stall,
// load formatting and the MEM/WB pipeline register.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic        i_mem_rd,
    input  logic        i_mem_wr,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_alu_data,
    input  logic [31:0] i_rs2_data,
    input  logic [4:0]  i_rd_addr,
    input  logic        i_rd_wren,
    mem_lsu_if.master   dmem,
    output logic        o_stall,
    output logic        o_misalign,
    output logic        o_bus_err,
    output logic        o_wb_valid,
    output logic [31:0] o_wb_data,
    output logic [4:0]  o_wb_rd_addr,
    output logic        o_wb_rd_wren
);

    localparam logic [4:0] CNT_LAST = 5'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state_q, state_d;
    logic [4:0]  cnt_q;
    logic        req_q, we_q, ld_q, wren_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;

    logic        wb_valid_q, wb_wren_q;
    logic [31:0] wb_data_q;
    logic [4:0]  wb_rd_q;
    logic        misalign_q, bus_err_q;

    logic        memop, aligned;
    logic        issue, done, abort, stall;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [31:0] ld_data;

    assign memop = i_valid & (i_mem_rd | i_mem_wr);

    always_comb begin
        be_n    = 4'b1111;
        wdata_n = i_rs2_data;
        aligned = 1'b0;
        unique case (1'b1)
            (i_funct3[1:0] == F3_B[1:0]): begin
                be_n    = 4'b0001 << i_alu_data[1:0];
                wdata_n = {4{i_rs2_data[7:0]}};
                aligned = 1'b1;
            end
            (i_funct3[1:0] == F3_H[1:0]): begin
                be_n    = 4'b0011 << {i_alu_data[1], 1'b0};
                wdata_n = {2{i_rs2_data[15:0]}};
                aligned = ~i_alu_data[0];
            end
            default: aligned = (i_alu_data[1:0] == 2'b00);
        endcase
    end

    // Ack in the final allowed cycle beats the timeout.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (memop && aligned) begin
                    issue   = 1'b1;
                    stall   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                done  = dmem.ack;
                abort = ~dmem.ack & (cnt_q == CNT_LAST);
                stall = ~done & ~abort;
                if (done || abort) state_d = IDLE;
            end
        endcase
    end

    lsu_load_fmt u_fmt (
        .rdata  (dmem.rdata),
        .off    (off_q),
        .funct3 (f3_q),
        .data   (ld_data)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            ld_q       <= 1'b0;
            wren_q     <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            f3_q       <= 3'd0;
            off_q      <= 2'd0;
            rd_q       <= 5'd0;
            wb_valid_q <= 1'b0;
            wb_wren_q  <= 1'b0;
            wb_data_q  <= 32'd0;
            wb_rd_q    <= 5'd0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            if (issue) begin
                req_q      <= 1'b1;
                cnt_q      <= 5'd0;
                we_q       <= i_mem_wr;
                ld_q       <= i_mem_rd & ~i_mem_wr;
                wren_q     <= i_rd_wren;
                addr_q     <= {i_alu_data[31:2], 2'b00};
                off_q      <= i_alu_data[1:0];
                wdata_q    <= wdata_n;
                be_q       <= be_n;
                f3_q       <= i_funct3;
                rd_q       <= i_rd_addr;
                wb_valid_q <= 1'b0;
            end else if (done) begin
                req_q      <= 1'b0;
                wb_valid_q <= 1'b1;
                wb_data_q  <= ld_data;
                wb_rd_q    <= rd_q;
                wb_wren_q  <= ld_q & wren_q;
            end else if (abort) begin
                req_q      <= 1'b0;
                wb_valid_q <= 1'b1;
                wb_data_q  <= 32'd0;
                wb_rd_q    <= rd_q;
                wb_wren_q  <= 1'b0;
                bus_err_q  <= 1'b1;
            end else if (state_q == WAIT) begin
                cnt_q      <= cnt_q + 5'd1;
                wb_valid_q <= 1'b0;
            end else if (memop) begin
                wb_valid_q <= 1'b1;
                wb_data_q  <= i_alu_data;
                wb_rd_q    <= i_rd_addr;
                wb_wren_q  <= 1'b0;
                misalign_q <= 1'b1;
            end else begin
                wb_valid_q <= i_valid;
                wb_data_q  <= i_alu_data;
                wb_rd_q    <= i_rd_addr;
                wb_wren_q  <= i_rd_wren & i_valid;
            end
        end
    end

    assign dmem.req     = req_q;
    assign dmem.we      = we_q;
    assign dmem.addr    = addr_q;
    assign dmem.wdata   = wdata_q;
    assign dmem.be      = be_q;
    assign o_stall      = stall;
    assign o_misalign   = misalign_q;
    assign o_bus_err    = bus_err_q;
    assign o_wb_valid   = wb_valid_q;
    assign o_wb_data    = wb_data_q;
    assign o_wb_rd_addr = wb_rd_q;
    assign o_wb_rd_wren = wb_wren_q;

endmodule

// File: doc/mem_lsu.md
# mem_lsu

MEM-stage load/store unit of the 5-stage RV32I pipeline. It sits directly downstream of the EX stage and consumes the ALU result, used as the address or pass-through value, and the forwarded rs2 store data. It runs a request/acknowledge transaction to data memory, stalling the front of the pipe until completion. It also formats load data and drives the MEM/WB pipeline register.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: max WAIT cycles without ack before abort (≥2).

Ports:
- i_clk  in  1  clock; all state on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_valid  in  1  EX/MEM slot holds a real instruction
- i_mem_rd / i_mem_wr  in  1  load / store
- i_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- i_alu_data  in  32  address (mem op) or result (non-mem op)
- i_rs2_data  in  32  store data (forwarded)
- i_rd_addr  in  5 / i_rd_wren  in  1  destination
- o_dmem_req  out  1  request, registered, held until ack/abort
- o_dmem_we  out  1  1 = store
- o_dmem_addr  out  32  word address, {addr[31:2],2'b00}
- o_dmem_wdata  out  32 / o_dmem_be  out  4  lane-replicated data, byte enables
- i_dmem_ack  in  1 / i_dmem_rdata  in  32  completion, read word
- o_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- o_misalign  out  1 / o_bus_err  out  1  1-cycle pulses, aligned with o_wb_valid
- o_wb_valid  out  1 / o_wb_data  out  32 / o_wb_rd_addr  out  5 / o_wb_rd_wren  out  1  MEM/WB register

## Operation
- FSM IDLE/WAIT; 5-bit cycle counter cnt.
- memop = i_valid & (i_mem_rd|i_mem_wr). Aligned: B any; H addr[0]=0; W addr[1:0]=0.
- IDLE, no memop: WB register loads {i_valid, i_alu_data, i_rd_addr, i_rd_wren&i_valid}; no stall.
- IDLE, memop misaligned: no request; WB loads valid=1, wren=0, o_misalign=1; no stall.
- IDLE, memop aligned: latch addr/we/be/wdata/funct3/rd; o_dmem_req<=1; cnt<=0; →WAIT; o_stall=1.
- WAIT: o_stall = ~i_dmem_ack & ~timeout. On ack: req<=0, →IDLE. WB loads valid=1, rd, wren = load & latched wren, data = formatted rdata.
- Timeout = cnt==TIMEOUT_CYCLES-1 & ~ack: req<=0, →IDLE, WB valid=1, wren=0, o_bus_err=1. Ack in the same cycle wins.
- Store lanes: SB be=0001<<a[1:0], wdata={4{rs2[7:0]}}; SH be=0011<<{a[1],1'b0}, wdata={2{rs2[15:0]}}; SW be=1111.
- Load format: w = rdata>>(8*a[1:0]); B/H sign-extend w[7:0]/w[15:0]; BU/HU zero-extend; W = rdata.
- Stores never write rd (wren=0).

## Timing
- Reset: state IDLE, cnt 0, o_dmem_req/we/addr/wdata/be 0, all o_wb_* 0, pulses 0, o_stall 0 once reset seen.
- Mem op at input cycle 0: o_stall=1 at c0. Req is visible at c1. Ack at c1 gives o_stall=0 at c1; upstream advances at the c1 edge and o_wb_* are valid at c2. Minimum 1 stall cycle; each extra ack-delay cycle adds one.
- Upstream holds inputs stable while o_stall=1. The completed op is not reissued because the state returns to IDLE on the same edge the pipe advances.
- Non-mem op: o_wb_* valid the cycle after presentation.
- Bubble (i_valid=0) in IDLE: o_wb_valid<=0.
- Reset asserted in WAIT: request abandoned at that edge; no WB result.
- The dmem side may hold ack for one cycle only. rdata is sampled in the ack cycle.

## Structure
- Package lsu_pkg: funct3 size constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum lsu_state_e {IDLE, WAIT}.
- Sub-module lsu_load_fmt: combinational rdata/offset/funct3 → 32-bit load value. Store lane logic stays inline.

## Test plan
- SW a=0x100, rs2=0xDEADBEEF, ack 1 cycle after req → addr 0x100, be 1111, wdata DEADBEEF, we=1, o_stall high 1 cycle, o_wb_valid=1, wren=0.
- LB a=0x103, rdata=0x80FF0000, ack delay 3 → o_wb_data=0xFFFFFF80, o_stall high 4 cycles; repeat as LBU → 0x00000080.
- SH a=0x102, rs2=0x1234ABCD → be 1100, wdata 0xABCDABCD, dmem addr 0x100.
- LW a=0x101 → no o_dmem_req, o_misalign pulse, o_wb_rd_wren=0, o_stall never high.
- Load with ack never returned, TIMEOUT_CYCLES=16 → req high 16 cycles then drops, o_bus_err pulse, wren=0. Ack in 16th cycle → normal completion, no bus_err.
- LW followed by ADD result 0x5: after the load retires, the ADD appears on o_wb_* one cycle later. Reset mid-WAIT → req 0 and o_wb_valid 0 next cycle.
